// File: rtl/mul_defs.sv
// Shared definitions for the sequential unsigned multiply path.
//   MULTU   : operation code that requests an unsigned multiply
//   state_t : controller states with fixed binary encoding
//   WIDTH   : default operand width (product is 2*WIDTH)
//   CNT_W   : default step-counter width
package mul_defs;

    localparam int         WIDTH = 32;
    localparam int         CNT_W = 6;
    localparam logic [2:0] MULTU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/multu_step.sv
// One combinational shift-add iteration of the unsigned multiplier.
//   acc_i / acc_o       : partial product before / after this step (2*WIDTH)
//   mcand_i / mcand_o   : multiplicand, shifted left one place per step (2*WIDTH)
//   mplier_i / mplier_o : multiplier, shifted right one place per step (WIDTH)
module multu_step #(
    parameter int WIDTH = mul_defs::WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    // The sum is kept at 2*WIDTH bits: for WIDTH-bit operands the carry out
    // of the top bit can never be set, so dropping it loses nothing.
    assign acc_o    = acc_i + (mplier_i[0] ? mcand_i : '0);
    assign mcand_o  = mcand_i << 1;
    assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/multu_seq_ctrl.sv
// Sequential controller for the unsigned WIDTH x WIDTH multiply.
// Captures operands on an accepted MULTU request, runs WIDTH shift-add steps
// (one per clock), commits the product to HI/LO and pulses done.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start, signal : request strobe and operation code (accepted only for MULTU in IDLE)
//   abort         : cancels a running multiply; HI/LO untouched, no done pulse
//   dataA, dataB  : multiplicand / multiplier, sampled on accept
//   busy          : high while running and in the done cycle
//   done          : one-cycle pulse, HI/LO valid in that cycle
//   hi, lo        : registered upper / lower product halves
//   dataOut       : {hi, lo}
module multu_seq_ctrl
    import mul_defs::*;
#(
    parameter int WIDTH = mul_defs::WIDTH,
    parameter int CNT_W = mul_defs::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         signal,
    input  logic               abort,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0]   step_mplier;

    multu_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (step_acc),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                // abort outranks a simultaneous request
                if (start && (signal == MULTU) && !abort) begin
                    mcand_d  = {{WIDTH{1'b0}}, dataA};
                    mplier_d = dataB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort also outranks the final step, so HI/LO stay untouched
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        hi_d    = step_acc[2*WIDTH-1:WIDTH];
                        lo_d    = step_acc[WIDTH-1:0];
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: they describe the state being entered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: the datapath registers sit on the async reset too, because a
    // reset must visibly clear HI/LO and discard any partial product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign dataOut = {hi_q, lo_q};

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Self-checking bench for multu_seq_ctrl: directed scenarios plus randomized
// operands and busy-time request noise, checked against plain 64-bit
// multiplication and the fixed request-to-done latency.
module tb_multu_seq_ctrl;
    import mul_defs::*;

    localparam int LAT = 32;  // clock edges from accept edge to the done cycle

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  signal;
    logic        abort;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] dataOut;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_prod;  // model of what HI/LO must hold

    multu_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .signal  (signal),
        .abort   (abort),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Waits for done after an accept edge; optionally fires ignored MULTU
    // requests with junk operands while the multiply is running.
    task automatic wait_done(input string tag, input bit noise, output int n);
        n = 0;
        while (!done && n < LAT + 8) begin
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                signal = MULTU;
                dataA  = $urandom;
                dataB  = $urandom;
            end
            tick();
            n++;
        end
        start = 1'b0;
        if (!done) check({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        signal = MULTU;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
    endtask

    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input string tag, input bit noise);
        int n;
        accept(a, b);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, noise, n);
        last_prod = ref_mul(a, b);
        check({tag, "_lat"}, 64'(n), 64'(LAT));
        check({tag, "_prod"}, dataOut, last_prod);
        check({tag, "_hilo"}, {hi, lo}, last_prod);
        abort = 1'($urandom_range(0, 1));  // ignored in the done cycle
        tick();
        abort = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
        check({tag, "_hold"}, dataOut, last_prod);
    endtask

    initial begin
        int n;
        int done_seen;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; signal = 3'b000; abort = 1'b0;
        dataA = '0; dataB = '0; last_prod = '0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", dataOut, 64'd0);
        rst = 1'b0;
        tick();

        // Basic product and latency
        mul_op(32'd3, 32'd5, "t1", 1'b0);
        check("t1_val", dataOut, 64'h0000_0000_0000_000F);

        // Abort mid-run: HI/LO keep 15, no done pulse
        accept(32'd2, 32'd2);
        for (int e = 1; e <= 10; e++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hold", dataOut, 64'h0000_0000_0000_000F);
        done_seen = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_nodone", 64'(done_seen), 64'd0);

        // Corner operands
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2a", 1'b0);
        check("t2a_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("t2a_lo", 64'(lo), 64'h0000_0000_0000_0001);
        mul_op(32'd0, 32'h1234_5678, "t2b", 1'b0);

        // Requests while busy are ignored
        accept(32'd3, 32'd5);
        for (int e = 1; e <= LAT; e++) begin
            if (e == 5 || e == 20) begin
                start = 1'b1; signal = MULTU; dataA = 32'd7; dataB = 32'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        last_prod = 64'd15;
        check("t3_done", 64'(done), 64'd1);
        check("t3_prod", dataOut, 64'd15);
        tick();
        check("t3_idle", 64'(busy), 64'd0);
        mul_op(32'd7, 32'd9, "t3b", 1'b0);
        check("t3b_val", dataOut, 64'd63);

        // Start held through the done cycle: ignored there, accepted next edge
        accept(32'd11, 32'd13);
        wait_done("b2b1", 1'b0, n);
        last_prod = ref_mul(32'd11, 32'd13);
        check("b2b1_prod", dataOut, last_prod);
        a = $urandom; b = $urandom;
        start = 1'b1; signal = MULTU; dataA = a; dataB = b;
        tick();
        check("b2b_done_ignored", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        check("b2b_accept", 64'(busy), 64'd1);
        wait_done("b2b2", 1'b0, n);
        last_prod = ref_mul(a, b);
        check("b2b2_lat", 64'(n), 64'(LAT));
        check("b2b2_prod", dataOut, last_prod);
        tick();

        // Reset mid-run clears everything immediately
        accept(32'd100, 32'd200);
        for (int e = 1; e <= 16; e++) tick();
        #2 rst = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_out", dataOut, 64'd0);
        last_prod = '0;
        tick();
        rst = 1'b0;
        tick();
        mul_op(32'd6, 32'd7, "t5", 1'b0);
        check("t5_val", dataOut, 64'd42);

        // Non-MULTU request and start+abort in IDLE
        start = 1'b1; signal = 3'b010;
        tick(); tick();
        check("op010_busy", 64'(busy), 64'd0);
        signal = MULTU; abort = 1'b1;
        tick();
        check("start_abort_busy", 64'(busy), 64'd0);
        start = 1'b0; abort = 1'b0;
        tick();
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_hold", dataOut, last_prod);

        // Random operands with busy-time request noise
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'hFFFF_FFFF;
            if (i == 1) b = 32'h8000_0000;
            mul_op(a, b, $sformatf("rnd%0d", i), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
